// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the core (C) and debug (D) requesters.
// Each granted request runs one fixed-latency memory access and returns a one-cycle response strobe.
module dmem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              c_req_valid,
   output logic              c_req_ready,
   input  logic              c_req_we,
   input  logic [ADDR_W-1:0] c_req_addr,
   input  logic [DATA_W-1:0] c_req_wdata,
   output logic              c_rsp_valid,
   output logic [DATA_W-1:0] c_rsp_rdata,

   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy,
   output logic              grant_id
);

   generate
      if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_lat
         $error("dmem_arbiter: MEM_LAT must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        cnt_q;
   logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

   logic              any_valid;
   logic              win_id;
   logic              accept;
   logic              capture;

   // Tie goes to the port that did not win last time; a lone requester always wins.
   assign any_valid = c_req_valid | d_req_valid;
   assign win_id    = (c_req_valid & d_req_valid) ? ~last_grant_q : d_req_valid;
   // Gating with reset keeps ready low while reset is held, even with valid inputs.
   assign accept    = reset & (state_q == S_IDLE) & any_valid;
   assign capture   = (state_q == S_WAIT) && (cnt_q == 4'd1);

   assign c_req_ready = accept & ~win_id;
   assign d_req_ready = accept &  win_id;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= 4'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q      <= win_id;
            last_grant_q <= win_id;
            we_q         <= win_id ? d_req_we    : c_req_we;
            addr_q       <= win_id ? d_req_addr  : c_req_addr;
            wdata_q      <= win_id ? d_req_wdata : c_req_wdata;
         end
         if (state_q == S_ISSUE) begin
            cnt_q <= LAT_CNT;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // NOTE: read-data holding registers are reset too, since every output must read 0 in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (capture && !we_q) begin
         if (owner_q) d_rdata_q <= mem_rdata;
         else         c_rdata_q <= mem_rdata;
      end
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q  : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;

   assign c_rsp_valid = (state_q == S_RESP) & ~owner_q;
   assign d_rsp_valid = (state_q == S_RESP) &  owner_q;
   assign c_rsp_rdata = c_rdata_q;
   assign d_rsp_rdata = d_rdata_q;

   assign busy     = (state_q != S_IDLE);
   assign grant_id = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: cycle-numbered transaction model plus directed scenarios and random traffic.
module tb_dmem_arbiter;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid;
   logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
   logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic        mem_en, mem_we, busy, grant_id;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] wr_mem [logic [31:0]];
   logic [31:0] rd_sched [int];

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
      .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (wr_mem.exists(a)) return wr_mem[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Memory: read data appears exactly LAT cycles after mem_en; other cycles carry noise.
   always begin
      @(posedge clk);
      #1;
      if (rd_sched.exists(cyc)) begin
         mem_rdata = rd_sched[cyc];
         rd_sched.delete(cyc);
      end else begin
         mem_rdata = $urandom;
      end
   end

   // Transaction model: one transaction occupies cycles acc..acc+LAT+2, idle again at acc+LAT+3.
   bit          m_live, m_owner, m_we, m_last;
   int          m_acc;
   logic [31:0] m_addr, m_wdata, m_data;
   logic [31:0] m_rd [2];
   bit          idle, any, w, en_exp, rv;

   always @(negedge clk) begin
      if (!reset) begin
         check("rst_mem_en", mem_en, 0);
         check("rst_busy", busy, 0);
         check("rst_c_ready", c_req_ready, 0);
         check("rst_d_ready", d_req_ready, 0);
         check("rst_c_rsp", c_rsp_valid, 0);
         check("rst_d_rsp", d_rsp_valid, 0);
         check("rst_c_rdata", c_rsp_rdata, 0);
         check("rst_d_rdata", d_rsp_rdata, 0);
         m_live = 0;
         m_last = 1;
         m_rd[0] = 32'h0;
         m_rd[1] = 32'h0;
      end else begin
         if (mem_en) begin
            if (mem_we) wr_mem[mem_addr] = mem_wdata;
            else        rd_sched[cyc + LAT] = mem_val(mem_addr);
         end
         idle = !m_live || (cyc >= m_acc + LAT + 3);
         any  = c_req_valid || d_req_valid;
         w    = (c_req_valid && d_req_valid) ? !m_last : d_req_valid;
         rv   = m_live && (cyc == m_acc + LAT + 2);
         if (rv && !m_we) m_rd[m_owner] = m_data;
         en_exp = m_live && (cyc == m_acc + 1);
         check("c_req_ready", c_req_ready, idle && any && !w);
         check("d_req_ready", d_req_ready, idle && any && w);
         check("busy", busy, !idle);
         if (!idle) check("grant_id", grant_id, m_owner);
         check("mem_en", mem_en, en_exp);
         if (en_exp) begin
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
         end
         check("c_rsp_valid", c_rsp_valid, rv && !m_owner);
         check("d_rsp_valid", d_rsp_valid, rv && m_owner);
         check("c_rsp_rdata", c_rsp_rdata, m_rd[0]);
         check("d_rsp_rdata", d_rsp_rdata, m_rd[1]);
         if (idle && any) begin
            m_live  = 1;
            m_acc   = cyc;
            m_owner = w;
            m_last  = w;
            m_we    = w ? d_req_we    : c_req_we;
            m_addr  = w ? d_req_addr  : c_req_addr;
            m_wdata = w ? d_req_wdata : c_req_wdata;
            m_data  = mem_val(m_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req_valid = 0; c_req_we = 0; c_req_addr = 0; c_req_wdata = 0;
      d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      tick();
      tick();
      reset = 1;
   endtask

   int          nc, nd, ng, ne, nr, rst_cnt;
   logic [3:0]  glog;
   bit          c_act, d_act, c_acc, d_acc, c_we, d_we;
   logic [31:0] c_addr, d_addr, c_wd, d_wd;

   initial begin
      wr_mem[32'h10] = 32'hDEADBEEF;
      idle_inputs();
      do_reset();

      // Core read of 0x10: ready at T, mem_en at T+1, response at T+LAT+2.
      c_req_valid = 1; c_req_addr = 32'h10; #1;
      check("p1_c_ready", c_req_ready, 1);
      tick(); c_req_valid = 0; c_req_addr = $urandom; #1;
      check("p1_mem_en", mem_en, 1);
      check("p1_mem_addr", mem_addr, 32'h10);
      check("p1_mem_we", mem_we, 0);
      repeat (LAT) begin tick(); #1; check("p1_early_rsp", c_rsp_valid, 0); end
      tick(); #1;
      check("p1_rsp_valid", c_rsp_valid, 1);
      check("p1_rsp_rdata", c_rsp_rdata, 32'hDEADBEEF);
      tick();

      // Both ports valid from reset: C, D, C, D.
      do_reset();
      c_req_valid = 1; c_req_addr = 32'h4; d_req_valid = 1; d_req_addr = 32'h8;
      glog = 0; ng = 0; nc = 0; nd = 0;
      for (int i = 0; i < 4 * (LAT + 3); i++) begin
         #1;
         if (mem_en) begin glog = {grant_id, glog[3:1]}; ng++; end
         if (c_rsp_valid) nc++;
         if (d_rsp_valid) nd++;
         tick();
      end
      idle_inputs();
      check("p2_grants", ng, 4);
      check("p2_order", glog, 4'b1010);
      check("p2_c_rsp_count", nc, 2);
      check("p2_d_rsp_count", nd, 2);

      // Debug write; core stays silent, debug read data unchanged.
      do_reset();
      d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h20; d_req_wdata = 32'hA5A5A5A5; #1;
      check("p3_d_ready", d_req_ready, 1);
      check("p3_c_ready", c_req_ready, 0);
      tick(); idle_inputs(); #1;
      check("p3_mem_en", mem_en, 1);
      check("p3_mem_we", mem_we, 1);
      check("p3_mem_addr", mem_addr, 32'h20);
      check("p3_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      nc = 0;
      repeat (LAT) begin
         tick(); #1;
         if (c_rsp_valid) nc++;
         check("p3_early_rsp", d_rsp_valid, 0);
      end
      tick(); #1;
      if (c_rsp_valid) nc++;
      check("p3_d_rsp", d_rsp_valid, 1);
      check("p3_d_rdata", d_rsp_rdata, 32'h0);
      check("p3_c_quiet", nc, 0);
      tick();

      // Debug waits behind a core read until the arbiter is idle again.
      c_req_valid = 1; c_req_addr = 32'h10; #1;
      check("p4_c_ready", c_req_ready, 1);
      tick(); c_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h30;
      for (int k = 1; k <= LAT + 2; k++) begin
         #1;
         check("p4_d_blocked", d_req_ready, 0);
         if (k == LAT + 2) check("p4_c_rsp", c_rsp_valid, 1);
         tick();
      end
      #1;
      check("p4_d_ready", d_req_ready, 1);
      tick(); idle_inputs();
      repeat (LAT + 3) tick();

      // Reset during WAIT discards the transaction; next read completes normally.
      c_req_valid = 1; c_req_addr = 32'h10;
      tick(); idle_inputs();
      tick(); tick();
      #2;
      reset = 0; c_req_valid = 1; d_req_valid = 1;
      #1;
      check("p5_mem_en", mem_en, 0);
      check("p5_busy", busy, 0);
      check("p5_c_ready", c_req_ready, 0);
      check("p5_d_ready", d_req_ready, 0);
      check("p5_c_rdata", c_rsp_rdata, 0);
      check("p5_grant_id", grant_id, 0);
      tick(); tick();
      idle_inputs(); reset = 1;
      nc = 0;
      c_req_valid = 1; c_req_addr = 32'h10; #1;
      check("p5_c_ready_after", c_req_ready, 1);
      tick(); idle_inputs();
      repeat (LAT + 1) begin #1; if (c_rsp_valid) nc++; tick(); end
      #1;
      check("p5_no_stale_rsp", nc, 0);
      check("p5_rsp_valid", c_rsp_valid, 1);
      check("p5_rsp_rdata", c_rsp_rdata, 32'hDEADBEEF);
      tick();

      // A one-cycle debug pulse while busy is never serviced.
      c_req_valid = 1; c_req_addr = 32'h8;
      tick(); idle_inputs();
      ne = 0; nr = 0;
      for (int k = 1; k <= LAT + 6; k++) begin
         d_req_valid = (k == 2);
         d_req_addr = $urandom;
         #1;
         if (mem_en) ne++;
         if (d_req_ready) nr++;
         tick();
      end
      check("p6_mem_en_count", ne, 1);
      check("p6_d_ready_count", nr, 0);

      // Random traffic with occasional abandoned requests and resets.
      c_act = 0; d_act = 0; c_acc = 0; d_acc = 0; rst_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rst_cnt > 0) begin
            rst_cnt--;
            reset = 0;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_cnt = 1;
            reset = 0;
         end else begin
            reset = 1;
         end
         if (!reset || c_acc || ($urandom_range(0, 19) == 0)) c_act = 0;
         else if (!c_act && ($urandom_range(0, 2) == 0)) begin
            c_act = 1; c_we = 1'($urandom_range(0, 1));
            c_addr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
         end
         if (!reset || d_acc || ($urandom_range(0, 19) == 0)) d_act = 0;
         else if (!d_act && ($urandom_range(0, 2) == 0)) begin
            d_act = 1; d_we = 1'($urandom_range(0, 1));
            d_addr = 32'($urandom_range(0, 15)) << 2; d_wd = $urandom;
         end
         c_req_valid = c_act;
         c_req_we    = c_act ? c_we : 1'($urandom_range(0, 1));
         c_req_addr  = c_act ? c_addr : $urandom;
         c_req_wdata = c_act ? c_wd : $urandom;
         d_req_valid = d_act;
         d_req_we    = d_act ? d_we : 1'($urandom_range(0, 1));
         d_req_addr  = d_act ? d_addr : $urandom;
         d_req_wdata = d_act ? d_wd : $urandom;
         #1;
         c_acc = c_req_valid && c_req_ready;
         d_acc = d_req_valid && d_req_ready;
         tick();
      end
      idle_inputs();
      reset = 1;
      repeat (LAT + 6) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
